// File: rtl/data_io_pkg.sv
// Shared constants and types for the SPI download buffer: io-controller
// command codes and the download state encoding.
package data_io_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        ERASE = 2'd3
    } state_e;

endpackage

// File: rtl/data_io_fifo.sv
// First-word-fall-through FIFO holding {address, data, byte-enable} entries
// between the SPI byte packer and the RAM write handshake.
module data_io_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign cnt_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o = (cnt_o == '0);
    assign full_o  = (cnt_o == (PW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q[PW-1:0]];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers, and a resettable array would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
    end

endmodule

// File: rtl/data_io_buf.sv
// SPI download controller: oversampled slave SPI -> DW-bit word packer ->
// FIFO -> wr/wr_ack RAM port. Define DATA_IO_ERASE_EN to fill the tail of
// the image region with FILL after a download.
module data_io_buf
    import data_io_pkg::*;
#(
    parameter int unsigned AW        = 25,
    parameter int unsigned DW        = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ERASE_END = 'h8000,
    parameter logic [7:0]  FILL      = 8'h00
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sck,
    input  logic            ss,
    input  logic            sdi,
    output logic            downloading,
    output logic [4:0]      index,
    output logic            overflow,
    output logic            wr,
    input  logic            wr_ack,
    output logic [AW-1:0]   a,
    output logic [DW-1:0]   d,
    output logic [DW/8-1:0] be
);

`ifdef DATA_IO_ERASE_EN
    localparam bit ERASE_EN = 1'b1;
`else
    localparam bit ERASE_EN = 1'b0;
`endif

    localparam int unsigned NB    = DW / 8;
    localparam int unsigned LW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned EW    = AW + DW + NB;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [AW:0] END_W = (AW+1)'(ERASE_END);

    // ---------------- SPI receiver ----------------
    logic [2:0] sck_sync_q;
    logic [1:0] ss_sync_q, sdi_sync_q;
    logic       sck_rise, ss_s, sdi_s;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic [7:0] byte_q, cmd_q;
    logic       byte_stb_q, have_cmd_q;

    assign sck_rise = sck_sync_q[1] && !sck_sync_q[2];
    assign ss_s     = ss_sync_q[1];
    assign sdi_s    = sdi_sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q <= '0;
            ss_sync_q  <= 2'b11;
            sdi_sync_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            cmd_q      <= '0;
            byte_stb_q <= 1'b0;
            have_cmd_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[1:0], sck};
            ss_sync_q  <= {ss_sync_q[0], ss};
            sdi_sync_q <= {sdi_sync_q[0], sdi};
            byte_stb_q <= 1'b0;
            if (ss_s) begin
                bit_cnt_q  <= '0;
                have_cmd_q <= 1'b0;
            end else begin
                if (sck_rise) begin
                    shift_q   <= {shift_q[5:0], sdi_s};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_q     <= {shift_q, sdi_s};
                        byte_stb_q <= 1'b1;
                    end
                end
                if (byte_stb_q && !have_cmd_q) begin
                    cmd_q      <= byte_q;
                    have_cmd_q <= 1'b1;
                end
            end
        end
    end

    // ---------------- command decode ----------------
    state_e state_q, state_d;
    logic   pay_stb, start, stop, dat, idx;

    assign pay_stb = byte_stb_q && have_cmd_q;
    assign start   = pay_stb && (cmd_q == UIO_FILE_TX) && (byte_q != 8'h00);
    assign stop    = pay_stb && (cmd_q == UIO_FILE_TX) && (byte_q == 8'h00) && (state_q == LOAD);
    assign dat     = pay_stb && (cmd_q == UIO_FILE_TX_DAT) && (state_q == LOAD);
    assign idx     = pay_stb && (cmd_q == UIO_FILE_INDEX);

    // ---------------- datapath state ----------------
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [NB-1:0] acc_be_q, acc_be_d;
    logic [4:0]    index_q, index_d;
    logic          ovf_q, ovf_d;
    logic          wr_q, wr_d, infl_q, infl_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] d_q, d_d;
    logic [NB-1:0] be_q, be_d;

    logic          push, pop, flush;
    logic [EW-1:0] push_word, head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic          below_end, last_fill, drain_last;
    logic [AW:0]   addr_nxt;

    assign addr_nxt   = {1'b0, addr_q} + (AW+1)'(1);
    assign below_end  = ({1'b0, addr_q} < END_W);
    assign last_fill  = (addr_nxt >= END_W);
    // Final drain write is the one being acknowledged with nothing behind it.
    assign drain_last = wr_q ? (wr_ack && (infl_q ? (fifo_cnt == CW'(1)) : fifo_empty))
                             : fifo_empty;

    // NOTE: every signal written here receives a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lane_d    = lane_q;
        acc_d     = acc_q;
        acc_be_d  = acc_be_q;
        index_d   = index_q;
        ovf_d     = ovf_q;
        wr_d      = wr_q;
        infl_d    = infl_q;
        a_d       = a_q;
        d_d       = d_q;
        be_d      = be_q;
        push      = 1'b0;
        push_word = '0;
        pop       = 1'b0;
        flush     = 1'b0;

        if (wr_q && wr_ack) begin
            wr_d   = 1'b0;
            pop    = infl_q;
            infl_d = 1'b0;
            if (state_q == ERASE) begin
                addr_d = addr_q + AW'(1);
                if (last_fill) state_d = IDLE;
            end
        end

        if (start) begin
            state_d  = LOAD;
            addr_d   = AW'(BASE_ADDR);
            flush    = 1'b1;
            ovf_d    = 1'b0;
            lane_d   = '0;
            acc_d    = '0;
            acc_be_d = '0;
            infl_d   = 1'b0;
        end else if (dat) begin
            for (int i = 0; i < NB; i++) begin
                if (lane_q == LW'(i)) begin
                    acc_d[i*8 +: 8] = byte_q;
                    acc_be_d[i]     = 1'b1;
                end
            end
            if (lane_q == LW'(NB-1)) begin
                push      = 1'b1;
                push_word = {addr_q, acc_d, {NB{1'b1}}};
                addr_d    = addr_q + AW'(1);
                lane_d    = '0;
                acc_d     = '0;
                acc_be_d  = '0;
            end else begin
                lane_d = lane_q + LW'(1);
            end
        end else if (stop) begin
            if (acc_be_q != '0) begin
                push      = 1'b1;
                push_word = {addr_q, acc_q, acc_be_q};
                addr_d    = addr_q + AW'(1);
            end
            lane_d   = '0;
            acc_d    = '0;
            acc_be_d = '0;
            state_d  = DRAIN;
        end

        if (idx) index_d = byte_q[4:0];

        // A pop in the same cycle frees the slot, so only a real full drops.
        if (push && fifo_full && !pop) ovf_d = 1'b1;

        if (!wr_q && !fifo_empty && !start) begin
            wr_d   = 1'b1;
            infl_d = 1'b1;
            a_d    = head[EW-1 -: AW];
            d_d    = head[NB +: DW];
            be_d   = head[NB-1:0];
        end

        if (state_q == DRAIN && !start) begin
            if (ERASE_EN && index_q != 5'd0 && below_end) begin
                if (fifo_empty && !wr_q) begin
                    state_d = ERASE;
                    wr_d    = 1'b1;
                    infl_d  = 1'b0;
                    a_d     = addr_q;
                    d_d     = {NB{FILL}};
                    be_d    = '1;
                end
            end else if (drain_last) begin
                state_d = IDLE;
            end
        end

        if (state_q == ERASE && !wr_q && !start) begin
            wr_d   = 1'b1;
            infl_d = 1'b0;
            a_d    = addr_q;
            d_d    = {NB{FILL}};
            be_d   = '1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            lane_q   <= '0;
            acc_q    <= '0;
            acc_be_q <= '0;
            index_q  <= '0;
            ovf_q    <= 1'b0;
            wr_q     <= 1'b0;
            infl_q   <= 1'b0;
            a_q      <= '0;
            d_q      <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lane_q   <= lane_d;
            acc_q    <= acc_d;
            acc_be_q <= acc_be_d;
            index_q  <= index_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            infl_q   <= infl_d;
            a_q      <= a_d;
            d_q      <= d_d;
            be_q     <= be_d;
        end
    end

    data_io_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (push_word),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (fifo_cnt)
    );

    assign downloading = (state_q != IDLE);
    assign index       = index_q;
    assign overflow    = ovf_q;
    assign wr          = wr_q;
    assign a           = a_q;
    assign d           = d_q;
    assign be          = be_q;

endmodule

// File: tb/tb_data_io_buf.sv
// Directed bench for data_io_buf: an 8-bit and a 16-bit instance share one
// SPI link; each RAM port has its own wr_ack and a write log.
module tb_data_io_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0, ss = 1'b1, sdi = 1'b0;
    logic ack8 = 1'b0, ack16 = 1'b0;

    logic        dl8, ovf8, wr8;
    logic [4:0]  idx8;
    logic [24:0] a8;
    logic [7:0]  d8;
    logic [0:0]  be8;

    logic        dl16, ovf16, wr16;
    logic [4:0]  idx16;
    logic [24:0] a16;
    logic [15:0] d16;
    logic [1:0]  be16;

    int n_cmp = 0;
    int n_err = 0;

    logic [24:0] la8[$];
    logic [7:0]  ld8[$];
    logic [0:0]  lb8[$];
    logic [24:0] la16[$];
    logic [15:0] ld16[$];
    logic [1:0]  lb16[$];

    always #5 clk = ~clk;

    data_io_buf #(.AW(25), .DW(8), .DEPTH(16), .BASE_ADDR(0), .ERASE_END(8), .FILL(8'hE5)) dut8 (
        .clk(clk), .reset_n(rst_n), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl8), .index(idx8), .overflow(ovf8),
        .wr(wr8), .wr_ack(ack8), .a(a8), .d(d8), .be(be8)
    );

    data_io_buf #(.AW(25), .DW(16), .DEPTH(16), .BASE_ADDR(0), .ERASE_END(8), .FILL(8'hE5)) dut16 (
        .clk(clk), .reset_n(rst_n), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl16), .index(idx16), .overflow(ovf16),
        .wr(wr16), .wr_ack(ack16), .a(a16), .d(d16), .be(be16)
    );

    always @(negedge clk) begin
        if (wr8 && ack8) begin
            la8.push_back(a8); ld8.push_back(d8); lb8.push_back(be8);
        end
        if (wr16 && ack16) begin
            la16.push_back(a16); ld16.push_back(d16); lb16.push_back(be16);
        end
    end

    task automatic clear_logs();
        la8.delete(); ld8.delete(); lb8.delete();
        la16.delete(); ld16.delete(); lb16.delete();
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sdi = b[i];
            #40 sck = 1'b1;
            #40 sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8);
    endtask

    task automatic ss_low();
        ss = 1'b0;
        #80;
    endtask

    task automatic ss_high();
        #80 ss = 1'b1;
        #160;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [7:0] p);
        ss_low();
        spi_byte(c);
        spi_byte(p);
        ss_high();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((dl8 || dl16) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (dl8 || dl16) begin
            n_err++;
            $display("FAIL %s idle: downloading8=%b downloading16=%b after %0d clk, required 0", tag, dl8, dl16, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (wr8 !== 1'b0)   begin n_err++; $display("FAIL reset wr: got %b need 0", wr8); end
        n_cmp++; if (a8 !== 25'd0)   begin n_err++; $display("FAIL reset a: got %h need 0", a8); end
        n_cmp++; if (d8 !== 8'd0)    begin n_err++; $display("FAIL reset d: got %h need 0", d8); end
        n_cmp++; if (be8 !== 1'b0)   begin n_err++; $display("FAIL reset be: got %b need 0", be8); end
        n_cmp++; if (dl8 !== 1'b0)   begin n_err++; $display("FAIL reset downloading: got %b need 0", dl8); end
        n_cmp++; if (idx8 !== 5'd0)  begin n_err++; $display("FAIL reset index: got %0d need 0", idx8); end
        n_cmp++; if (ovf8 !== 1'b0)  begin n_err++; $display("FAIL reset overflow: got %b need 0", ovf8); end
        n_cmp++; if (d16 !== 16'd0)  begin n_err++; $display("FAIL reset d16: got %h need 0", d16); end
    endtask

    task automatic test_dw8_basic();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
        ack8 = 1'b1; ack16 = 1'b1;
        clear_logs();
        send_cmd(8'h53, 8'h01);
        n_cmp++; if (dl8 !== 1'b1) begin n_err++; $display("FAIL dw8 start downloading: got %b need 1", dl8); end
        ss_low();
        spi_byte(8'h54);
        for (int i = 0; i < 4; i++) spi_byte(exp_d[i]);
        ss_high();
        send_cmd(8'h53, 8'h00);
        wait_idle("dw8");
        n_cmp++;
        if (la8.size() != 4) begin
            n_err++; $display("FAIL dw8 count: got %0d writes need 4", la8.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (la8[i] !== 25'(i) || ld8[i] !== exp_d[i] || lb8[i] !== 1'b1) begin
                    n_err++;
                    $display("FAIL dw8 write%0d: got a=%0h d=%h be=%b need a=%0h d=%h be=1", i, la8[i], ld8[i], lb8[i], i, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_dw16_partial();
        clear_logs();
        send_cmd(8'h53, 8'h01);
        ss_low();
        spi_byte(8'h54);
        spi_byte(8'hAA); spi_byte(8'hBB); spi_byte(8'hCC);
        ss_high();
        send_cmd(8'h53, 8'h00);
        wait_idle("dw16");
        n_cmp++;
        if (la16.size() != 2) begin
            n_err++; $display("FAIL dw16 count: got %0d writes need 2", la16.size());
        end else begin
            n_cmp++;
            if (la16[0] !== 25'd0 || ld16[0] !== 16'hBBAA || lb16[0] !== 2'b11) begin
                n_err++; $display("FAIL dw16 full word: got a=%0h d=%h be=%b need a=0 d=bbaa be=11", la16[0], ld16[0], lb16[0]);
            end
            n_cmp++;
            if (la16[1] !== 25'd1 || ld16[1][7:0] !== 8'hCC || lb16[1] !== 2'b01) begin
                n_err++; $display("FAIL dw16 partial: got a=%0h d[7:0]=%h be=%b need a=1 d[7:0]=cc be=01", la16[1], ld16[1][7:0], lb16[1]);
            end
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        ack8 = 1'b0;
        send_cmd(8'h53, 8'h01);
        ss_low();
        spi_byte(8'h54);
        for (int i = 1; i <= 20; i++) spi_byte(8'(i));
        ss_high();
        send_cmd(8'h53, 8'h00);
        n_cmp++; if (ovf8 !== 1'b1) begin n_err++; $display("FAIL ovf flag: got %b need 1", ovf8); end
        n_cmp++; if (wr8 !== 1'b1 || a8 !== 25'd0 || d8 !== 8'h01) begin
            n_err++; $display("FAIL ovf held write: got wr=%b a=%0h d=%h need wr=1 a=0 d=01", wr8, a8, d8);
        end
        @(negedge clk);
        ack8 = 1'b1;
        wait_idle("ovf");
        n_cmp++;
        if (la8.size() != 16) begin
            n_err++; $display("FAIL ovf count: got %0d writes need 16", la8.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (la8[i] !== 25'(i) || ld8[i] !== 8'(i + 1)) begin
                    n_err++; $display("FAIL ovf write%0d: got a=%0h d=%h need a=%0h d=%h", i, la8[i], ld8[i], i, i + 1);
                end
            end
        end
        n_cmp++; if (ovf8 !== 1'b1) begin n_err++; $display("FAIL ovf sticky: got %b need 1", ovf8); end
    endtask

    task automatic test_fill();
        int exp_n;
        clear_logs();
        send_cmd(8'h55, 8'h03);
        n_cmp++; if (idx8 !== 5'd3) begin n_err++; $display("FAIL fill index: got %0d need 3", idx8); end
        send_cmd(8'h53, 8'h01);
        n_cmp++; if (ovf8 !== 1'b0) begin n_err++; $display("FAIL start clears overflow: got %b need 0", ovf8); end
        ss_low();
        spi_byte(8'h54); spi_byte(8'h01); spi_byte(8'h02);
        ss_high();
        send_cmd(8'h53, 8'h00);
        wait_idle("fill3");
`ifdef DATA_IO_ERASE_EN
        exp_n = 8;
`else
        exp_n = 2;
`endif
        n_cmp++;
        if (la8.size() != exp_n) begin
            n_err++; $display("FAIL fill3 count: got %0d writes need %0d", la8.size(), exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                n_cmp++;
                if (la8[i] !== 25'(i) || ld8[i] !== ((i < 2) ? 8'(i + 1) : 8'hE5) || lb8[i] !== 1'b1) begin
                    n_err++; $display("FAIL fill3 write%0d: got a=%0h d=%h be=%b", i, la8[i], ld8[i], lb8[i]);
                end
            end
        end
        clear_logs();
        send_cmd(8'h55, 8'h00);
        send_cmd(8'h53, 8'h01);
        ss_low();
        spi_byte(8'h54); spi_byte(8'h01); spi_byte(8'h02);
        ss_high();
        send_cmd(8'h53, 8'h00);
        wait_idle("fill0");
        n_cmp++; if (la8.size() != 2) begin n_err++; $display("FAIL fill0 count: got %0d writes need 2", la8.size()); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        ack8 = 1'b0;
        send_cmd(8'h53, 8'h01);
        ss_low();
        spi_byte(8'h54); spi_byte(8'h31); spi_byte(8'h32); spi_byte(8'h33);
        ss_high();
        n_cmp++; if (wr8 !== 1'b1) begin n_err++; $display("FAIL rstmid pending: got wr=%b need 1", wr8); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (wr8 !== 1'b0 || a8 !== 25'd0 || d8 !== 8'd0 || be8 !== 1'b0 || dl8 !== 1'b0 || ovf8 !== 1'b0 || idx8 !== 5'd0) begin
            n_err++; $display("FAIL rstmid outputs: got wr=%b a=%0h d=%h be=%b dl=%b ovf=%b idx=%0d need all 0", wr8, a8, d8, be8, dl8, ovf8, idx8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ack8 = 1'b1;
        repeat (3) @(negedge clk);
        clear_logs();
        send_cmd(8'h53, 8'h01);
        ss_low();
        spi_byte(8'h54); spi_byte(8'h77); spi_byte(8'h88);
        ss_high();
        send_cmd(8'h53, 8'h00);
        wait_idle("rstmid");
        n_cmp++;
        if (la8.size() != 2 || la8[0] !== 25'd0 || ld8[0] !== 8'h77 || la8[1] !== 25'd1 || ld8[1] !== 8'h88) begin
            n_err++; $display("FAIL rstmid restart: got %0d writes, need a=0 d=77 then a=1 d=88", la8.size());
        end
    endtask

    task automatic test_ss_abort();
        clear_logs();
        send_cmd(8'h53, 8'h01);
        ss_low();
        spi_byte(8'h54); spi_byte(8'h11);
        spi_bits(8'hC3, 5);
        ss_high();
        ss_low();
        spi_byte(8'h54); spi_byte(8'h5A);
        ss_high();
        send_cmd(8'h53, 8'h00);
        wait_idle("ssabort");
        n_cmp++;
        if (la8.size() != 2) begin
            n_err++; $display("FAIL ssabort count: got %0d writes need 2", la8.size());
        end else begin
            n_cmp++;
            if (la8[0] !== 25'd0 || ld8[0] !== 8'h11 || la8[1] !== 25'd1 || ld8[1] !== 8'h5A) begin
                n_err++; $display("FAIL ssabort data: got a=%0h d=%h, a=%0h d=%h need a=0 d=11, a=1 d=5a", la8[0], ld8[0], la8[1], ld8[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dw8_basic();
        test_dw16_partial();
        test_overflow();
        test_fill();
        test_reset_mid();
        test_ss_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
